// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: the payload carried between stages by the
// elastic buffers, and its packed width for sizing those buffers.
package lc3b_types;

   typedef struct packed {
      logic [3:0] opcode;
      logic [2:0] dest_reg;
      logic       ld_reg;
      logic       ld_cc;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
   } stage_ctrl_t;

   typedef struct packed {
      stage_ctrl_t ctrl;
      logic [15:0] pc;
      logic [15:0] src_a;
      logic [15:0] src_b;
   } stage_payload_t;

   localparam int STAGE_PAYLOAD_W = $bits(stage_payload_t);

endpackage

// File: rtl/pipe_elastic_buffer_pkg.sv
// Helpers for the elastic buffer: pointer sizing and explicit modulo-DEPTH
// pointer advance, so non-power-of-two depths wrap correctly.
package pipe_elastic_buffer_pkg;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/pipe_elastic_buffer_chk.sv
// Simulation-only protocol checks for pipe_elastic_buffer, observed purely
// through its ports.
module pipe_elastic_buffer_chk #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2,
   parameter int CW    = 2
) (
   input logic             clk,
   input logic             reset,
   input logic             flush,
   input logic             in_valid,
   input logic             in_ready,
   input logic             out_valid,
   input logic             out_ready,
   input logic [WIDTH-1:0] out_data,
   input logic [CW-1:0]    count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   a_count_bound: assert property (@(posedge clk) disable iff (reset)
      count <= DEPTH_C);

   a_no_push_full: assert property (@(posedge clk) disable iff (reset)
      !(in_valid && in_ready && !flush && (count == DEPTH_C)));

   a_head_stable: assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule

// File: rtl/pipe_elastic_buffer.sv
// Elastic pipeline buffer: DEPTH-entry circular FIFO with valid/ready on both
// sides, synchronous flush, and zero-valued out_data whenever it is empty.
module pipe_elastic_buffer
   import pipe_elastic_buffer_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CW-1:0]    count
);

   localparam int            PW      = ptr_width(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_s, pop_s, in_ready_s, out_valid_s;

   // Handshake qualifiers derived only from registered state and this cycle's inputs.
   always_comb begin
      in_ready_s  = (count_q < DEPTH_C);
      out_valid_s = (count_q != {CW{1'b0}});
      push_s      = in_valid & in_ready_s & ~flush;
      pop_s       = out_valid_s & out_ready & ~flush;
   end

   // Next-state for pointers, occupancy and storage; flush wins over push/pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      mem_d   = mem_q;
      if (flush) begin
         head_d  = {PW{1'b0}};
         tail_d  = {PW{1'b0}};
         count_d = {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_d[tail_q] = in_data;
            tail_d        = PW'(next_ptr(32'(tail_q), DEPTH));
         end else begin
            tail_d = tail_q;
         end
         if (pop_s) begin
            head_d = PW'(next_ptr(32'(head_q), DEPTH));
         end else begin
            head_d = head_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with synchronous reset; reset also outranks flush and push.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= {PW{1'b0}};
         tail_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset: it is only ever read while count is nonzero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Outputs come straight from registers; an empty buffer presents a zero bubble.
   always_comb begin
      in_ready  = in_ready_s;
      out_valid = out_valid_s;
      count     = count_q;
      if (out_valid_s) begin
         out_data = mem_q[head_q];
      end else begin
         out_data = {WIDTH{1'b0}};
      end
   end

   pipe_elastic_buffer_chk #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_chk (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

endmodule

// File: tb/tb_pipe_elastic_buffer.sv
// Bench for pipe_elastic_buffer: a DEPTH=2 and a DEPTH=3 instance checked each
// cycle against a queue-style reference log of accepted words.
module tb_pipe_elastic_buffer;

   logic        clk;
   logic        reset;
   logic        fl   [2];
   logic        iv   [2];
   logic [15:0] id   [2];
   logic        ordy [2];
   logic        irdy [2];
   logic        ov   [2];
   logic [15:0] od   [2];
   logic [1:0]  cnt  [2];

   int total;
   int bad;

   // reference: every accepted word is logged; entries [mr, mw) are held
   logic [15:0] mdata [2][4096];
   int          mw    [2];
   int          mr    [2];
   int          dep   [2];

   pipe_elastic_buffer #(.WIDTH(16), .DEPTH(2)) dut2 (
      .clk(clk), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_data(id[0]),
      .in_ready(irdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]),
      .count(cnt[0]));

   pipe_elastic_buffer #(.WIDTH(16), .DEPTH(3)) dut3 (
      .clk(clk), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_data(id[1]),
      .in_ready(irdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]),
      .count(cnt[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // check both DUTs against the reference, then advance one clock
   task automatic tick();
      bit push [2];
      bit pop  [2];
      for (int k = 0; k < 2; k++) begin
         int occ;
         occ = mw[k] - mr[k];
         chk($sformatf("d%0d.count", dep[k]), 32'(cnt[k]), occ);
         chk($sformatf("d%0d.in_ready", dep[k]), 32'(irdy[k]), 32'(occ < dep[k]));
         chk($sformatf("d%0d.out_valid", dep[k]), 32'(ov[k]), 32'(occ != 0));
         chk($sformatf("d%0d.out_data", dep[k]), 32'(od[k]),
             (occ != 0) ? 32'(mdata[k][mr[k] % 4096]) : 32'd0);
         push[k] = iv[k] && (occ < dep[k]) && !fl[k];
         pop[k]  = (occ != 0) && ordy[k] && !fl[k];
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (reset || fl[k]) begin
            mr[k] = mw[k];
         end else begin
            if (pop[k]) mr[k]++;
            if (push[k]) begin
               mdata[k][mw[k] % 4096] = id[k];
               mw[k]++;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < 2; k++) begin
         fl[k] = 1'b0; iv[k] = 1'b0; id[k] = 16'h0; ordy[k] = 1'b0;
      end
   endtask

   initial begin
      total = 0; bad = 0;
      dep[0] = 2; dep[1] = 3;
      mw[0] = 0; mw[1] = 0; mr[0] = 0; mr[1] = 0;
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset state, then idle for 5 cycles
      chk("reset.in_ready", 32'(irdy[0]), 32'd1);
      chk("reset.out_data", 32'(od[0]), 32'd0);
      repeat (5) tick();

      // fill DEPTH=2, refuse third push, drain in order
      iv[0] = 1'b1; id[0] = 16'h1111; tick();
      id[0] = 16'h2222; tick();
      chk("fill.count", 32'(cnt[0]), 32'd2);
      chk("fill.in_ready", 32'(irdy[0]), 32'd0);
      id[0] = 16'h3333; tick();
      iv[0] = 1'b0; ordy[0] = 1'b1;
      chk("drain.first", 32'(od[0]), 32'h1111);
      tick();
      chk("drain.second", 32'(od[0]), 32'h2222);
      tick();
      chk("drain.empty", 32'(ov[0]), 32'd0);
      tick();

      // streaming: one word per cycle, occupancy stays at 1
      iv[0] = 1'b1; ordy[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         id[0] = 16'(i);
         tick();
         chk("stream.count", 32'(cnt[0]), 32'd1);
      end
      iv[0] = 1'b0; tick(); tick();

      // flush collides with a push and a pop
      ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 16'h0101; tick();
      id[0] = 16'h0202; tick();
      fl[0] = 1'b1; id[0] = 16'hBEEF; ordy[0] = 1'b1; tick();
      fl[0] = 1'b0; iv[0] = 1'b0;
      chk("flush.count", 32'(cnt[0]), 32'd0);
      chk("flush.out_data", 32'(od[0]), 32'd0);
      tick(); tick();

      // DEPTH=3: push/pop pairs interleaved with stalls to force pointer wrap
      for (int i = 0; i < 7; i++) begin
         iv[1] = 1'b1; id[1] = 16'h3000 + 16'(i); ordy[1] = 1'b0; tick();
         iv[1] = 1'b0; ordy[1] = 1'(i % 2); tick();
         ordy[1] = 1'b1; tick();
      end
      ordy[1] = 1'b1; repeat (4) tick();
      idle_inputs();

      // reset mid-operation with a simultaneous push
      iv[0] = 1'b1; id[0] = 16'h0A0A; tick();
      id[0] = 16'h0B0B; tick();
      reset = 1'b1; id[0] = 16'h0055; tick();
      reset = 1'b0; iv[0] = 1'b1; id[0] = 16'h00AA;
      chk("rst_mid.count", 32'(cnt[0]), 32'd0);
      tick();
      iv[0] = 1'b0;
      chk("rst_mid.out_data", 32'(od[0]), 32'h00AA);
      ordy[0] = 1'b1; tick(); tick();

      // randomized traffic on both instances
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < 2; k++) begin
            iv[k]   = 1'($urandom_range(0, 3) != 0);
            ordy[k] = 1'($urandom_range(0, 2) != 0);
            fl[k]   = 1'($urandom_range(0, 19) == 0);
            id[k]   = 16'($urandom);
         end
         reset = 1'($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;
      idle_inputs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
